lspc_timer_bank: RTL and testbench

LSPC_TIMER_BANK -- requirements
Module: lspc_timer_bank

---
 rtl/lspc_timer_bank.sv | 119 +++++++++++
 tb/tb_lspc_timer_bank.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lspc_timer_bank.sv
// lspc_timer_bank: bank of independent down-counting timers with programmable reload.
//
// Each channel holds a reload register written as two 16-bit halves from the CPU bus.
// The channel counter decrements on every tick (RUN_EN high and not halted).
// The counter is reloaded by any of three mode-selected triggers:
// the cycle after a low-half write, a frame start, or an expiry.
// An expiry is a tick taken while the counter reads zero.
// Without an expiry reload, an expiry either wraps the counter to all-ones
// or, in one-shot mode, parks the counter at zero and halts the channel.
//
// Ports:
//   TIMER_CLK, nRESET        clock, asynchronous active-low reset
//   M68K_DATA                16-bit write data
//   WR_TIMER_HIGH/LOW[n]     per-channel write strobes for reload[WIDTH-1:16] / reload[15:0]
//   TIMER_MODE[3n+2:3n]      bit0 reload on low write, bit1 on frame start, bit2 on expiry
//   ONESHOT[n]               halt at zero after expiry
//   TIMER_IRQ_EN[n]          per-channel IRQ enable
//   IRQ_ACK[n]               clear the pending flag
//   FRAME_START, RUN_EN      shared frame pulse and global count enable
//   TIMER_IRQ[n], IRQ_ANY    registered pending flags and their OR
//   COUNT                    live counters, channel 0 in the LSBs
module lspc_timer_bank #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 32
) (
  input  logic                      TIMER_CLK,
  input  logic                      nRESET,
  input  logic [15:0]               M68K_DATA,
  input  logic [CHANNELS-1:0]       WR_TIMER_HIGH,
  input  logic [CHANNELS-1:0]       WR_TIMER_LOW,
  input  logic [3*CHANNELS-1:0]     TIMER_MODE,
  input  logic [CHANNELS-1:0]       ONESHOT,
  input  logic [CHANNELS-1:0]       TIMER_IRQ_EN,
  input  logic [CHANNELS-1:0]       IRQ_ACK,
  input  logic                      FRAME_START,
  input  logic                      RUN_EN,
  output logic [CHANNELS-1:0]       TIMER_IRQ,
  output logic                      IRQ_ANY,
  output logic [CHANNELS*WIDTH-1:0] COUNT
);

  logic [WIDTH-1:0]    reload_q [CHANNELS];
  logic [WIDTH-1:0]    reload_d [CHANNELS];
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [CHANNELS-1:0] halted_q, halted_d;
  logic [CHANNELS-1:0] irq_q, irq_d;
  // Delayed low-write strobe: the low-write reload uses the value latched by that write.
  logic [CHANNELS-1:0] wr_low_q;
  logic                irq_any_q;

  logic [CHANNELS-1:0] tick, expiry, do_reload;

  always_comb begin
    tick      = '0;
    expiry    = '0;
    do_reload = '0;
    halted_d  = halted_q;
    irq_d     = irq_q;
    for (int n = 0; n < CHANNELS; n++) begin
      reload_d[n] = reload_q[n];
      if (WR_TIMER_HIGH[n]) reload_d[n][WIDTH-1:16] = M68K_DATA[WIDTH-17:0];
      if (WR_TIMER_LOW[n])  reload_d[n][15:0]       = M68K_DATA;

      tick[n]      = RUN_EN & ~halted_q[n];
      expiry[n]    = tick[n] & (count_q[n] == '0);
      do_reload[n] = (TIMER_MODE[3*n]   & wr_low_q[n]) |
                     (TIMER_MODE[3*n+1] & FRAME_START) |
                     (TIMER_MODE[3*n+2] & expiry[n]);

      // Reload uses reload_q, so a write in the same cycle takes effect one cycle later.
      count_d[n] = count_q[n];
      if (do_reload[n]) begin
        count_d[n]  = reload_q[n];
        halted_d[n] = 1'b0;
      end else if (expiry[n]) begin
        if (ONESHOT[n]) halted_d[n] = 1'b1;
        else            count_d[n]  = '1;
      end else if (tick[n]) begin
        count_d[n] = count_q[n] - WIDTH'(1);
      end

      // Enable gates everything; a set beats a coincident acknowledge.
      if (!TIMER_IRQ_EN[n])  irq_d[n] = 1'b0;
      else if (expiry[n])    irq_d[n] = 1'b1;
      else if (IRQ_ACK[n])   irq_d[n] = 1'b0;
    end
  end

  always_ff @(posedge TIMER_CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int n = 0; n < CHANNELS; n++) begin
        reload_q[n] <= '0;
        count_q[n]  <= '0;
      end
      halted_q  <= '0;
      irq_q     <= '0;
      wr_low_q  <= '0;
      irq_any_q <= 1'b0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        reload_q[n] <= reload_d[n];
        count_q[n]  <= count_d[n];
      end
      halted_q  <= halted_d;
      irq_q     <= irq_d;
      wr_low_q  <= WR_TIMER_LOW;
      irq_any_q <= |irq_d;
    end
  end

  assign TIMER_IRQ = irq_q;
  assign IRQ_ANY   = irq_any_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_count
    assign COUNT[g*WIDTH +: WIDTH] = count_q[g];
  end

endmodule

// File: tb/tb_lspc_timer_bank.sv
// Testbench for lspc_timer_bank (CHANNELS=2, WIDTH=32): hand-computed vector table,
// directed corner sequences and randomized traffic against a behavioural model.
module tb_lspc_timer_bank;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic [1:0]  wr_hi, wr_lo, oneshot, irq_en, ack;
  logic [5:0]  mode;
  logic        fs, run;
  logic [1:0]  timer_irq;
  logic        irq_any;
  logic [63:0] count;

  int checks;
  int failures;

  lspc_timer_bank #(.CHANNELS(2), .WIDTH(32)) dut (
    .TIMER_CLK    (clk),
    .nRESET       (rst_n),
    .M68K_DATA    (data),
    .WR_TIMER_HIGH(wr_hi),
    .WR_TIMER_LOW (wr_lo),
    .TIMER_MODE   (mode),
    .ONESHOT      (oneshot),
    .TIMER_IRQ_EN (irq_en),
    .IRQ_ACK      (ack),
    .FRAME_START  (fs),
    .RUN_EN       (run),
    .TIMER_IRQ    (timer_irq),
    .IRQ_ANY      (irq_any),
    .COUNT        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  logic [31:0] m_reload [2];
  logic [31:0] m_count  [2];
  logic        m_halt   [2];
  logic        m_lowpend[2];
  logic [1:0]  m_irq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_reload[c]  = '0;
      m_count[c]   = '0;
      m_halt[c]    = 1'b0;
      m_lowpend[c] = 1'b0;
    end
    m_irq = '0;
  endtask

  // Applies one clock edge worth of the timer rules to the model, using current inputs.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      logic [2:0]  md;
      logic [31:0] old_rl;
      logic        tk, ex, rl;
      md     = mode[3*c +: 3];
      old_rl = m_reload[c];
      if (wr_hi[c]) m_reload[c][31:16] = data;
      if (wr_lo[c]) m_reload[c][15:0]  = data;
      tk = run && !m_halt[c];
      ex = tk && (m_count[c] == 32'd0);
      rl = (md[0] && m_lowpend[c]) || (md[1] && fs) || (md[2] && ex);
      if (rl) begin
        m_count[c] = old_rl;
        m_halt[c]  = 1'b0;
      end else if (ex) begin
        if (oneshot[c]) m_halt[c] = 1'b1;
        else            m_count[c] = 32'hFFFF_FFFF;
      end else if (tk) begin
        m_count[c] = m_count[c] - 32'd1;
      end
      if (!irq_en[c])  m_irq[c] = 1'b0;
      else if (ex)     m_irq[c] = 1'b1;
      else if (ack[c]) m_irq[c] = 1'b0;
      m_lowpend[c] = wr_lo[c];
    end
  endtask

  task automatic compare_model();
    chk("model_count", count, {m_count[1], m_count[0]});
    chk("model_irq", {62'd0, timer_irq}, {62'd0, m_irq});
    chk("model_irq_any", {63'd0, irq_any}, {63'd0, |m_irq});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic drive(input logic [1:0] h, input logic [1:0] l, input logic [15:0] d,
                       input logic r, input logic f, input logic [1:0] a);
    wr_hi = h;
    wr_lo = l;
    data  = d;
    run   = r;
    fs    = f;
    ack   = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 2'b00);
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_model();
  endtask

  typedef struct packed {
    logic        hi;
    logic        lo;
    logic [15:0] d;
    logic        r;
    logic        f;
    logic        a;
    logic [31:0] e_cnt;
    logic        e_irq;
  } vec_t;

  vec_t tbl [13];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    mode     = '0;
    oneshot  = '0;
    irq_en   = '0;
    drive(2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 2'b00);
    model_reset();

    // Channel 0, expiry reload of 3: period of four ticks.
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'd3, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'd2, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'd3, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'd3, 1'b1};

    #12;
    chk("reset_count", count, 64'd0);
    chk("reset_irq", {62'd0, timer_irq}, 64'd0);
    chk("reset_irq_any", {63'd0, irq_any}, 64'd0);

    do_reset();
    mode   = 6'b000_100;
    irq_en = 2'b01;
    for (int i = 0; i < 13; i++) begin
      drive({1'b0, tbl[i].hi}, {1'b0, tbl[i].lo}, tbl[i].d, tbl[i].r, tbl[i].f,
            {1'b0, tbl[i].a});
      cycle();
      chk("tbl_count0", {32'd0, count[31:0]}, {32'd0, tbl[i].e_cnt});
      chk("tbl_irq0", {63'd0, timer_irq[0]}, {63'd0, tbl[i].e_irq});
    end

    // Channel 1 one-shot, reload on low write.
    do_reset();
    mode    = 6'b001_000;
    oneshot = 2'b10;
    irq_en  = 2'b10;
    drive(2'b10, 2'b00, 16'h0000, 1'b0, 1'b0, 2'b00); cycle();
    drive(2'b00, 2'b10, 16'h0002, 1'b0, 1'b0, 2'b00); cycle();
    drive(2'b00, 2'b00, 16'h0000, 1'b0, 1'b0, 2'b00); cycle();
    chk("os_load", {32'd0, count[63:32]}, 64'd2);
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00); cycle();
    chk("os_cnt1", {32'd0, count[63:32]}, 64'd1);
    cycle();
    chk("os_cnt0", {32'd0, count[63:32]}, 64'd0);
    chk("os_no_irq_yet", {63'd0, timer_irq[1]}, 64'd0);
    cycle();
    chk("os_halt_cnt", {32'd0, count[63:32]}, 64'd0);
    chk("os_irq", {63'd0, timer_irq[1]}, 64'd1);
    cycle();
    chk("os_irq_held", {63'd0, timer_irq[1]}, 64'd1);
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b10); cycle();
    chk("os_ack", {63'd0, timer_irq[1]}, 64'd0);
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("os_halted_irq", {63'd0, timer_irq[1]}, 64'd0);
      chk("os_halted_cnt", {32'd0, count[63:32]}, 64'd0);
    end
    drive(2'b00, 2'b10, 16'h0002, 1'b1, 1'b0, 2'b00); cycle();
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00); cycle();
    chk("os_restart", {32'd0, count[63:32]}, 64'd2);
    cycle();
    chk("os_restart_dec", {32'd0, count[63:32]}, 64'd1);

    // Frame-start reload mid-count suppresses the expiry.
    do_reset();
    mode   = 6'b000_010;
    irq_en = 2'b01;
    drive(2'b00, 2'b01, 16'h0010, 1'b0, 1'b0, 2'b00); cycle();
    drive(2'b00, 2'b00, 16'h0000, 1'b0, 1'b1, 2'b00); cycle();
    chk("fs_load", {32'd0, count[31:0]}, 64'h10);
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 9; i++) cycle();
    chk("fs_mid", {32'd0, count[31:0]}, 64'h7);
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 2'b00); cycle();
    chk("fs_reload", {32'd0, count[31:0]}, 64'h10);
    chk("fs_no_irq", {63'd0, timer_irq[0]}, 64'd0);

    // Free-running wrap, then ack coinciding with an expiry.
    do_reset();
    mode   = 6'b000_000;
    irq_en = 2'b01;
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00); cycle();
    chk("wrap_count", {32'd0, count[31:0]}, 64'hFFFF_FFFF);
    chk("wrap_irq", {63'd0, timer_irq[0]}, 64'd1);
    mode = 6'b000_010;
    drive(2'b00, 2'b00, 16'h0000, 1'b0, 1'b1, 2'b00); cycle();
    chk("wrap_fs_zero", {32'd0, count[31:0]}, 64'd0);
    mode = 6'b000_000;
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b01); cycle();
    chk("ack_vs_set", {63'd0, timer_irq[0]}, 64'd1);
    chk("ack_vs_set_any", {63'd0, irq_any}, 64'd1);

    // Run-enable freeze, then asynchronous reset with an IRQ pending.
    do_reset();
    mode   = 6'b000_100;
    irq_en = 2'b01;
    drive(2'b00, 2'b01, 16'h0005, 1'b0, 1'b0, 2'b00); cycle();
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00); cycle();
    chk("frz_load", {32'd0, count[31:0]}, 64'd5);
    cycle();
    drive(2'b00, 2'b00, 16'h0000, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("frz_count", {32'd0, count[31:0]}, 64'd4);
      chk("frz_irq", {63'd0, timer_irq[0]}, 64'd1);
    end
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00); cycle();
    chk("frz_resume", {32'd0, count[31:0]}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 64'd0);
    chk("arst_irq", {62'd0, timer_irq}, 64'd0);
    chk("arst_irq_any", {63'd0, irq_any}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("arst_hold", count, 64'd0);
    rst_n = 1'b1;
    drive(2'b00, 2'b00, 16'h0000, 1'b0, 1'b0, 2'b00); cycle();
    chk("arst_no_pulse", {63'd0, timer_irq[0]}, 64'd0);
    drive(2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00); cycle();
    chk("first_tick_expiry", {63'd0, timer_irq[0]}, 64'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 60 == 0) begin
        mode    = 6'($urandom);
        oneshot = 2'($urandom);
        irq_en  = 2'($urandom_range(1, 3));
      end
      for (int c = 0; c < 2; c++) begin
        wr_hi[c] = ($urandom_range(0, 15) == 0);
        wr_lo[c] = ($urandom_range(0, 7) == 0);
        ack[c]   = ($urandom_range(0, 7) == 0);
      end
      data = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      fs   = ($urandom_range(0, 19) == 0);
      run  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
